// File: rtl/conv_pkg.sv
// Shared defaults and width helpers for the NxN convolution filter.
// Imported by the coefficient bank and the filter top.
package conv_pkg;

  localparam int KSIZE_D  = 5;
  localparam int PIX_W_D  = 8;
  localparam int COEF_W_D = 16;
  localparam int SHIFT_D  = 8;
  localparam int KDEF_D   = 10;

  // Accumulator width that can hold n products without overflow
  function automatic int sum_w(input int n, input int prod_w);
    return prod_w + $clog2(n);
  endfunction

endpackage

// File: rtl/conv_coef_bank.sv
// Double-buffered kernel: shadow load pointer, full flag, commit and
// error pulse; exports the active kernel as a flat vector.
module conv_coef_bank
  import conv_pkg::*;
#(
  parameter int N      = KSIZE_D * KSIZE_D,
  parameter int COEF_W = COEF_W_D,
  parameter int KDEF   = KDEF_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic signed [COEF_W-1:0] wr_data,
  input  logic                     commit,
  output logic [N*COEF_W-1:0]      active_flat,
  output logic                     coef_error
);

  localparam int WP_W = (N > 1) ? $clog2(N) : 1;

  logic signed [COEF_W-1:0] shadow [N];
  logic signed [COEF_W-1:0] active [N];
  logic [WP_W-1:0]          wptr;
  logic                     full;
  logic                     commit_ok;

  assign commit_ok = commit && full;

  // Commit sees the pre-write full flag; a write completing a load wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        shadow[i] <= COEF_W'(KDEF);
        active[i] <= COEF_W'(KDEF);
      end
      wptr       <= '0;
      full       <= 1'b0;
      coef_error <= 1'b0;
    end else begin
      coef_error <= commit && !full;
      if (commit_ok) begin
        for (int i = 0; i < N; i++)
          active[i] <= shadow[i];
        full <= 1'b0;
      end
      if (wr_en) begin
        shadow[wptr] <= wr_data;
        if (wptr == WP_W'(N - 1)) begin
          wptr <= '0;
          full <= 1'b1;
        end else begin
          wptr <= wptr + WP_W'(1);
        end
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_flat
    assign active_flat[j*COEF_W +: COEF_W] = active[j];
  end

endmodule

// File: rtl/conv_filter_nxn.sv
// Three-stage NxN convolution: multiply, sum, normalise/saturate,
// with a double-buffered coefficient kernel.
module conv_filter_nxn
  import conv_pkg::*;
#(
  parameter int KSIZE  = KSIZE_D,
  parameter int PIX_W  = PIX_W_D,
  parameter int COEF_W = COEF_W_D,
  parameter int SHIFT  = SHIFT_D,
  parameter int KDEF   = KDEF_D
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [KSIZE*KSIZE*PIX_W-1:0]   pixel_data,
  input  logic                           pixel_data_valid,
  input  logic                           coef_wr_en,
  input  logic signed [COEF_W-1:0]       coef_wr_data,
  input  logic                           coef_commit,
  input  logic                           abs_mode,
  output logic [PIX_W-1:0]               convolved_data,
  output logic                           convolved_data_valid,
  output logic                           coef_error
);

  localparam int N      = KSIZE * KSIZE;
  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam int SUM_W  = sum_w(N, PROD_W);

  localparam logic signed [SUM_W-1:0] MAX_V =
    {{(SUM_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  logic [N*COEF_W-1:0]      active_flat;
  logic signed [COEF_W-1:0] coef [N];

  conv_coef_bank #(
    .N      (N),
    .COEF_W (COEF_W),
    .KDEF   (KDEF)
  ) u_bank (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (coef_wr_en),
    .wr_data     (coef_wr_data),
    .commit      (coef_commit),
    .active_flat (active_flat),
    .coef_error  (coef_error)
  );

  for (genvar j = 0; j < N; j++) begin : g_coef
    assign coef[j] = active_flat[j*COEF_W +: COEF_W];
  end

  logic signed [PROD_W-1:0] prod_q [N];
  logic signed [SUM_W-1:0]  sum_c;
  logic signed [SUM_W-1:0]  sum_q;
  logic signed [SUM_W-1:0]  r_c;
  logic signed [SUM_W-1:0]  mag_c;
  logic [PIX_W-1:0]         out_c;
  logic [2:0]               vld;
  logic                     abs1;
  logic                     abs2;

  // Products and sum carry no reset; the valid chain qualifies them
  always_ff @(posedge clk) begin
    for (int j = 0; j < N; j++) begin
      prod_q[j] <= PROD_W'($signed({1'b0, pixel_data[PIX_W*j +: PIX_W]}))
                 * PROD_W'(coef[j]);
    end
    sum_q <= sum_c;
    abs1  <= abs_mode;
    abs2  <= abs1;
  end

  always_comb begin
    sum_c = '0;
    for (int j = 0; j < N; j++)
      sum_c = sum_c + SUM_W'(prod_q[j]);
  end

  always_comb begin
    r_c   = sum_q >>> SHIFT;
    mag_c = r_c;
    if (r_c[SUM_W-1])
      mag_c = abs2 ? -r_c : '0;
    out_c = (mag_c > MAX_V) ? '1 : mag_c[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld            <= '0;
      convolved_data <= '0;
    end else begin
      vld <= {vld[1:0], pixel_data_valid};
      if (vld[1])
        convolved_data <= out_c;
    end
  end

  assign convolved_data_valid = vld[2];

endmodule

// File: tb/tb_conv_filter_nxn.sv
// Directed bench for conv_filter_nxn with a cycle-level reference model
// checked every cycle, plus hand-computed result checks.
module tb_conv_filter_nxn;

  localparam int K  = 5;
  localparam int N  = K * K;
  localparam int PW = 8;
  localparam int CW = 16;
  localparam int C  = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N*PW-1:0]   pixel_data = '0;
  logic              pixel_data_valid = 1'b0;
  logic              coef_wr_en = 1'b0;
  logic signed [CW-1:0] coef_wr_data = '0;
  logic              coef_commit = 1'b0;
  logic              abs_mode = 1'b0;
  logic [PW-1:0]     convolved_data;
  logic              convolved_data_valid;
  logic              coef_error;

  conv_filter_nxn dut (
    .clk                  (clk),
    .rst                  (rst),
    .pixel_data           (pixel_data),
    .pixel_data_valid     (pixel_data_valid),
    .coef_wr_en           (coef_wr_en),
    .coef_wr_data         (coef_wr_data),
    .coef_commit          (coef_commit),
    .abs_mode             (abs_mode),
    .convolved_data       (convolved_data),
    .convolved_data_valid (convolved_data_valid),
    .coef_error           (coef_error)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: kernel state and per-window expected results
  int m_act [N];
  int m_sh  [N];
  int m_wp;
  bit m_full;
  bit mv [3];
  int md [3];
  int exp_data;
  bit exp_err;

  function automatic int model_out(input logic [N*PW-1:0] w, input bit ab);
    longint s = 0;
    longint r;
    for (int j = 0; j < N; j++)
      s += longint'(w[PW*j +: PW]) * longint'(m_act[j]);
    r = s >>> 8;
    if (r < 0) r = ab ? -r : 0;
    if (r > 255) r = 255;
    return int'(r);
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        m_act[j] = 10;
        m_sh[j]  = 10;
      end
      m_wp = 0; m_full = 0;
      for (int i = 0; i < 3; i++) begin mv[i] = 0; md[i] = 0; end
      exp_data = 0; exp_err = 0;
    end else begin
      mv[2] = mv[1]; md[2] = md[1];
      mv[1] = mv[0]; md[1] = md[0];
      mv[0] = pixel_data_valid;
      md[0] = model_out(pixel_data, abs_mode);
      if (mv[2]) exp_data = md[2];
      exp_err = coef_commit && !m_full;
      if (coef_commit && m_full) begin
        m_act  = m_sh;
        m_full = 0;
      end
      if (coef_wr_en) begin
        m_sh[m_wp] = int'(coef_wr_data);
        if (m_wp == N - 1) begin m_wp = 0; m_full = 1; end
        else m_wp++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("valid", int'(convolved_data_valid), int'(mv[2]));
      chk("data", int'(convolved_data), exp_data);
      chk("coef_error", int'(coef_error), int'(exp_err));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [N*PW-1:0] mk_win(input int oth, input int ctr);
    logic [N*PW-1:0] w;
    for (int j = 0; j < N; j++)
      w[PW*j +: PW] = PW'((j == C) ? ctr : oth);
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic put_win(input logic [N*PW-1:0] w, input bit ab);
    pixel_data = w; abs_mode = ab; pixel_data_valid = 1'b1;
    tick();
    pixel_data_valid = 1'b0;
  endtask

  task automatic wr(input int v);
    coef_wr_en = 1'b1; coef_wr_data = CW'(v);
    tick();
    coef_wr_en = 1'b0;
  endtask

  task automatic load_centre(input int c);
    for (int j = 0; j < N; j++) wr((j == C) ? c : 0);
  endtask

  task automatic do_commit();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
  endtask

  // Waits for the result; latency must be exactly 3 cycles
  task automatic wait_result(input string nm, input int exp);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (convolved_data_valid) begin
        chk({nm, "_lat"}, i, 1);
        chk(nm, int'(convolved_data), exp);
        return;
      end
    end
    chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    int seen;
    tick();
    do_reset();
    chk_en = 1;
    chk("rst_valid", int'(convolved_data_valid), 0);
    chk("rst_data", int'(convolved_data), 0);
    chk("rst_err", int'(coef_error), 0);

    put_win(mk_win(255, 255), 0);
    wait_result("all255", 249);
    tick();
    chk("hold", int'(convolved_data), 249);

    for (int j = 0; j < 10; j++) wr(j * 7);
    do_commit();
    chk("short_err", int'(coef_error), 1);
    tick();
    chk("err_pulse", int'(coef_error), 0);
    put_win(mk_win(100, 100), 0);
    wait_result("all100", 97);

    do_reset();
    load_centre(256);
    do_commit();
    chk("ok_commit", int'(coef_error), 0);
    put_win(mk_win(200, 77), 0);
    wait_result("id77", 77);

    load_centre(-256);
    do_commit();
    put_win(mk_win(0, 50), 0);
    wait_result("neg_clamp", 0);
    put_win(mk_win(0, 50), 1);
    wait_result("neg_abs", 50);

    load_centre(1024);
    do_commit();
    put_win(mk_win(0, 200), 0);
    wait_result("sat", 255);

    // Back-to-back stream, kernel x4 -> x1 at window 5
    load_centre(256);
    for (int k = 0; k < 10; k++) begin
      pixel_data = mk_win(0, 10 + k);
      pixel_data_valid = 1'b1;
      abs_mode = 1'b0;
      coef_commit = (k == 4);
      tick();
      if (k >= 2)
        chk("stream", int'(convolved_data),
            (k - 2 <= 4) ? 4 * (8 + k) : (8 + k));
    end
    coef_commit = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pixel_data_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (convolved_data_valid) seen++;
    end
    chk("post_rst_valid", seen, 0);

    // Commit with write: commit uses pre-write shadow
    coef_commit = 1'b1; coef_wr_en = 1'b1; coef_wr_data = '0;
    tick();
    coef_commit = 1'b0; coef_wr_en = 1'b0;
    chk("cw_err", int'(coef_error), 1);
    for (int j = 1; j < N; j++) wr((j == C) ? 256 : 0);
    coef_commit = 1'b1; coef_wr_en = 1'b1; coef_wr_data = 16'sd5;
    tick();
    coef_commit = 1'b0; coef_wr_en = 1'b0;
    chk("cw_ok", int'(coef_error), 0);
    put_win(mk_win(200, 90), 0);
    wait_result("cw_kernel", 90);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/conv_filter_nxn.md
CONV_FILTER_NXN -- requirements
Module: conv_filter_nxn

Interface
REQ-001 The block SHALL have parameter KSIZE, default 5: kernel edge length; N = KSIZE*KSIZE taps.
REQ-002 The block SHALL have parameter PIX_W, default 8: unsigned pixel width.
REQ-003 The block SHALL have parameter COEF_W, default 16: signed coefficient width.
REQ-004 The block SHALL have parameter SHIFT, default 8: arithmetic right-shift normalisation.
REQ-005 The block SHALL have parameter KDEF, default 10: reset value of every active and shadow tap.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port pixel_data, input, N*PIX_W bits: window, tap j at bits [PIX_W*j +: PIX_W].
REQ-009 The block SHALL have port pixel_data_valid, input, 1 bit: window qualifier.
REQ-010 The block SHALL have port coef_wr_en, input, 1 bit: write one shadow coefficient.
REQ-011 The block SHALL have port coef_wr_data, input, COEF_W bits: signed coefficient.
REQ-012 The block SHALL have port coef_commit, input, 1 bit: request shadow-to-active swap.
REQ-013 The block SHALL have port abs_mode, input, 1 bit: 0 clamps negative results to 0, 1 takes the magnitude.
REQ-014 The block SHALL have port convolved_data, output, PIX_W bits: normalised, saturated result.
REQ-015 The block SHALL have port convolved_data_valid, output, 1 bit: result qualifier.
REQ-016 The block SHALL have port coef_error, output, 1 bit: one-cycle pulse on a rejected commit.

Function
REQ-017 Each pixel SHALL be zero-extended to PIX_W+1 bits signed before multiplication.
REQ-018 Stage 1 SHALL register N products, each PIX_W+COEF_W+1 bits signed.
REQ-019 Stage 2 SHALL register the signed sum, product width plus clog2(N) bits, with no overflow possible.
REQ-020 Stage 3 SHALL register the output as follows.
- r = sum >>> SHIFT.
- If r < 0: output 0 when abs_mode=0, otherwise |r|.
- The magnitude SHALL be saturated to 2^PIX_W-1.
REQ-021 Latency SHALL be exactly 3 cycles from the pixel_data_valid sample to convolved_data_valid.
- There is no backpressure.
- Valid SHALL propagate through a 3-deep shift register, one result per input cycle.
REQ-022 abs_mode SHALL be sampled with the window and pipelined alongside it.
REQ-023 convolved_data SHALL hold its last value while valid is low.
REQ-024 coef_wr_en SHALL write coef_wr_data into shadow[wptr] and increment wptr.
- When wptr = N-1, wptr SHALL wrap to 0 and shadow_full SHALL be set.
REQ-025 coef_commit with shadow_full=1 SHALL copy shadow to active in one cycle and clear shadow_full.
- Windows sampled on or after the following cycle SHALL use the new kernel.
- Windows already in flight SHALL keep the old products.
REQ-026 coef_commit with shadow_full=0 SHALL leave active, shadow and wptr unchanged and pulse coef_error for one cycle.
REQ-027 Simultaneous coef_wr_en and coef_commit SHALL be handled as follows.
- The commit is evaluated on the pre-write shadow_full.
- The write then lands in the shadow and counts toward the next load.
REQ-028 Further writes after shadow_full SHALL overwrite from tap 0 and leave shadow_full set.

Reset
REQ-029 On rst the block SHALL reset as follows.
- Active and shadow taps SHALL be set to KDEF.
- wptr SHALL be 0 and shadow_full SHALL be 0.
- All valid stages, convolved_data and coef_error SHALL be 0.
REQ-030 rst asserted mid-pipeline SHALL discard in-flight windows: no valid SHALL be emitted for them.

Structure
REQ-031 Package conv_pkg SHALL hold the default parameter values and a function computing the sum width.
REQ-032 Sub-module conv_coef_bank SHALL hold the shadow and active arrays, wptr, shadow_full, commit and error logic, and export the flat active kernel.

Verification
REQ-033 Reset defaults, all pixels 255, valid for 1 cycle SHALL give 249 (63750>>8) exactly 3 cycles later with valid high for 1 cycle.
REQ-034 Load 25 taps with centre 256 and the rest 0, then commit, then apply centre pixel 77 with others 200. The result SHALL be 77.
REQ-035 Centre tap -256, centre pixel 50:
- abs_mode=0 SHALL give 0.
- abs_mode=1 SHALL give 50.
REQ-036 Centre tap 1024, centre pixel 200 SHALL give 255, saturated from 800.
REQ-037 Write 10 taps, then commit: coef_error SHALL pulse, and an all-100 window SHALL still give 97.
REQ-038 Stream back-to-back windows across a commit and assert rst on the cycle after a valid input.
- Old and new kernels SHALL switch on the exact window boundary.
- No valid SHALL appear after rst.
